// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state encoding and width helper for the FIFO write arbiter.
// No ports; imported by fifo_write_arbiter and rr_priority_picker users.
package fifo_arb_pkg;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  typedef enum logic {
    S_IDLE   = ST_IDLE,
    S_LOCKED = ST_LOCKED
  } arb_state_e;

  // Width of a counter/index holding values 0..n-1, never less than 1.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin search, first set req bit at or above ptr, wrapping.
// Ports: req_i (N), ptr_i (IDX_W) in; found_o, idx_o (IDX_W) out.
module rr_priority_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  localparam int SW = IDX_W + 1;

  logic [SW-1:0] sum;

  // Walk offsets from far to near so the nearest hit wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    sum     = '0;
    for (int off = N - 1; off >= 0; off--) begin
      sum = SW'(ptr_i) + SW'(off);
      if (sum >= SW'(N)) sum = sum - SW'(N);
      if (req_i[sum[IDX_W-1:0]]) begin
        found_o = 1'b1;
        idx_o   = sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin sharing of one FIFO write port with free-size credit flow control.
// Ports: i_clk, i_reset (sync, high); per-requester i_req_valid/_data/_last, o_req_ready;
// FIFO side o_w_data, o_w_data_stb, i_fifo_free_size; status o_grant_idx, o_busy.
// Option: FIFO_ARB_BURST_LOCK_EN enables multi-beat locked bursts; otherwise one beat per grant.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]            i_req_last,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [DATA_WIDTH-1:0]         o_w_data,
  output logic                          o_w_data_stb,
  input  logic [$clog2(FIFO_DEPTH)-1:0] i_fifo_free_size,
  output logic [$clog2(NUM_REQ)-1:0]    o_grant_idx,
  output logic                          o_busy
);

  localparam int IDX_W = cnt_w(NUM_REQ);
  localparam int BC_W  = cnt_w(MAX_BURST + 1);
  localparam int FS_W  = $clog2(FIFO_DEPTH);

  arb_state_e state_q;

  logic [IDX_W-1:0]      rr_ptr_q;
  logic [IDX_W-1:0]      rr_ptr_d;
  logic [IDX_W-1:0]      owner_q;
  logic [IDX_W-1:0]      pick_idx;
  logic [BC_W-1:0]       beat_cnt_q;
  logic [BC_W-1:0]       beat_cnt_d;
  logic                  pick_found;
  logic                  room;
  logic                  accept;
  logic                  burst_end;
  logic [DATA_WIDTH-1:0] owner_data;

  rr_priority_picker #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (i_req_valid),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    // The FIFO count lags our registered strobe by one cycle,
    // so an in-flight word consumes one unit of free space.
    room = i_fifo_free_size > FS_W'(o_w_data_stb);
    o_req_ready = '0;
    if (state_q == S_LOCKED) o_req_ready[owner_q] = room;
    accept = (state_q == S_LOCKED) & room & i_req_valid[owner_q];
    owner_data = i_req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
    beat_cnt_d = beat_cnt_q + BC_W'(1);
    rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1))
             ? '0 : owner_q + IDX_W'(1);
`ifdef FIFO_ARB_BURST_LOCK_EN
    burst_end = i_req_last[owner_q]
              | (beat_cnt_q == BC_W'(MAX_BURST - 1));
`else
    burst_end = 1'b1;
`endif
  end

`ifndef FIFO_ARB_BURST_LOCK_EN
  logic unused_last;
  assign unused_last = ^i_req_last;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      beat_cnt_q   <= '0;
      o_w_data     <= '0;
      o_w_data_stb <= 1'b0;
    end else begin
      o_w_data_stb <= accept;
      if (accept) o_w_data <= owner_data;
      unique case (state_q)
        S_IDLE: begin
          if (pick_found) begin
            owner_q    <= pick_idx;
            beat_cnt_q <= '0;
            state_q    <= S_LOCKED;
          end
        end
        S_LOCKED: begin
          if (accept) begin
            beat_cnt_q <= beat_cnt_d;
            if (burst_end) begin
              state_q  <= S_IDLE;
              rr_ptr_q <= rr_ptr_d;
            end
          end
        end
      endcase
    end
  end

  assign o_grant_idx = owner_q;
  assign o_busy      = (state_q == S_LOCKED);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed and random stimulus against a behavioural arbiter/FIFO model.
// Works with FIFO_ARB_BURST_LOCK_EN defined or not.
module tb_fifo_write_arbiter;

  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int MB    = 4;

`ifdef FIFO_ARB_BURST_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  typedef struct packed {
    logic          l;
    logic [DW-1:0] d;
  } wd_t;

  logic            clk = 1'b0;
  logic            i_reset;
  logic [N-1:0]    i_req_valid;
  logic [N*DW-1:0] i_req_data;
  logic [N-1:0]    i_req_last;
  logic [N-1:0]    o_req_ready;
  logic [DW-1:0]   o_w_data;
  logic            o_w_data_stb;
  logic [2:0]      i_fifo_free_size;
  logic [1:0]      o_grant_idx;
  logic            o_busy;

  fifo_write_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .MAX_BURST  (MB)
  ) dut (
    .i_clk            (clk),
    .i_reset          (i_reset),
    .i_req_valid      (i_req_valid),
    .i_req_data       (i_req_data),
    .i_req_last       (i_req_last),
    .o_req_ready      (o_req_ready),
    .o_w_data         (o_w_data),
    .o_w_data_stb     (o_w_data_stb),
    .i_fifo_free_size (i_fifo_free_size),
    .o_grant_idx      (o_grant_idx),
    .o_busy           (o_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  wd_t q[N][$];
  logic [N-1:0] gate;
  int force_free;
  int pop_pct;
  int fcnt;

  bit            m_busy;
  bit            m_stb;
  int            m_owner;
  int            m_ptr;
  int            m_cnt;
  logic [DW-1:0] m_data;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int off = 0; off < N; off++)
      if (v[(ptr + off) % N]) return (ptr + off) % N;
    return -1;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < N; i++)
      if (q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_stb   = 1'b0;
    m_owner = 0;
    m_ptr   = 0;
    m_cnt   = 0;
    m_data  = '0;
  endtask

  task automatic push(input int k, input logic [DW-1:0] d, input bit l);
    q[k].push_back({l, d});
  endtask

  task automatic cyc(input bit rst);
    logic [N-1:0]    v;
    logic [N-1:0]    l;
    logic [N-1:0]    er;
    logic [N*DW-1:0] d;
    int              fr;
    int              o;
    bit              acc;
    bit              pop;
    @(negedge clk);
    v = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < N; i++)
      if (q[i].size() > 0) begin
        v[i] = gate[i];
        l[i] = q[i][0].l;
        d[i*DW +: DW] = q[i][0].d;
      end
    if (force_free >= 0) fr = force_free;
    else fr = (DEPTH - fcnt > 7) ? 7 : DEPTH - fcnt;
    i_req_valid      = v;
    i_req_last       = l;
    i_req_data       = d;
    i_fifo_free_size = 3'(fr);
    i_reset          = rst;
    #1;
    er = '0;
    if (m_busy && fr > (m_stb ? 1 : 0)) er[m_owner] = 1'b1;
    chk("ready", 32'(o_req_ready), 32'(er));
    chk("stb", 32'(o_w_data_stb), 32'(m_stb));
    chk("wdata", 32'(o_w_data), 32'(m_data));
    chk("grant", 32'(o_grant_idx), 32'(m_owner));
    chk("busy", 32'(o_busy), 32'(m_busy));
    if (force_free < 0)
      chk("overflow", 32'(o_w_data_stb && fcnt >= DEPTH), 32'd0);
    pop  = (fcnt > 0) && ($urandom_range(99) < pop_pct);
    fcnt = fcnt + (o_w_data_stb ? 1 : 0) - (pop ? 1 : 0);
    acc = m_busy && er[m_owner] && v[m_owner];
    if (acc) void'(q[m_owner].pop_front());
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      m_stb = 1'b0;
      o = pick(v, m_ptr);
      if (o >= 0) begin
        m_owner = o;
        m_cnt   = 0;
        m_busy  = 1'b1;
      end
    end else if (acc) begin
      m_data = d[m_owner*DW +: DW];
      m_stb  = 1'b1;
      if (!LOCK || l[m_owner] || m_cnt == MB - 1) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % N;
      end
      m_cnt++;
    end else begin
      m_stb = 1'b0;
    end
    @(posedge clk);
  endtask

  task automatic drain(input int lim);
    int n;
    bit done;
    n = 0;
    done = all_empty() && !m_busy && !m_stb;
    while (!done && n < lim) begin
      cyc(1'b0);
      n++;
      done = all_empty() && !m_busy && !m_stb;
    end
    chk("drain_bound", 32'(done), 32'd1);
  endtask

  initial begin
    i_reset          = 1'b1;
    i_req_valid      = '0;
    i_req_data       = '0;
    i_req_last       = '0;
    i_fifo_free_size = 3'd7;
    gate       = '1;
    force_free = -1;
    pop_pct    = 100;
    fcnt       = 0;
    model_reset();
    repeat (2) @(posedge clk);

    // Reset values.
    cyc(1'b0);

    // Single requester burst A,B,C.
    force_free = 7;
    push(0, 16'h000A, 1'b0);
    push(0, 16'h000B, 1'b0);
    push(0, 16'h000C, 1'b1);
    repeat (6) cyc(1'b0);
    drain(20);

    // Fairness between req0 and req2.
    for (int i = 0; i < 4; i++) begin
      push(0, 16'h1000 + 16'(i), 1'b1);
      push(2, 16'h2000 + 16'(i), 1'b1);
    end
    drain(40);

    // Credit limit at free_size 1.
    force_free = 1;
    for (int i = 0; i < 4; i++)
      push(0, 16'h3000 + 16'(i), i == 3);
    drain(40);
    force_free = 7;

    // Burst cap with competing requester.
    for (int i = 0; i < 6; i++)
      push(1, 16'h4100 + 16'(i), i == 5);
    push(3, 16'h4300, 1'b0);
    push(3, 16'h4301, 1'b1);
    drain(40);

    // Reset on the second beat.
    for (int i = 0; i < 4; i++)
      push(0, 16'h5000 + 16'(i), i == 3);
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b1);
    cyc(1'b0);
    drain(40);

    // Two requesters alternating per word.
    for (int i = 0; i < 6; i++) begin
      push(0, 16'h6000 + 16'(i), 1'b1);
      push(1, 16'h6100 + 16'(i), 1'b1);
    end
    drain(60);

    // Random traffic against the live FIFO count.
    force_free = -1;
    pop_pct    = 40;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (q[i].size() < 3 && $urandom_range(2) == 0)
          push(i, 16'($urandom), $urandom_range(3) == 0);
        gate[i] = $urandom_range(4) != 0;
      end
      pop_pct = (c % 150 < 60) ? 15 : 60;
      cyc(1'b0);
    end
    gate    = '1;
    pop_pct = 100;
    for (int i = 0; i < N; i++) push(i, 16'($urandom), 1'b1);
    drain(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter sharing one `fifo` write port among `NUM_REQ` producers. Each producer gets a locked burst of up to `MAX_BURST` words, delimited by `i_req_last`. Flow control uses the FIFO's `o_free_size` plus a one-word in-flight credit, so no word is ever strobed into a full FIFO. The arbiter sits directly in front of the FIFO write side; the FIFO read side is untouched.

## Interface
- `NUM_REQ`, default 4: number of requesters, must be ≥ 2.
- `DATA_WIDTH`, default 16: word width, equal to the FIFO `DATA_WIDTH`.
- `FIFO_DEPTH`, default 8: equal to the FIFO `MAX_ENTRIES`.
- `MAX_BURST`, default 4: maximum number of beats per grant, must be ≥ 1.
- `i_clk` in 1: clock.
- `i_reset` in 1: synchronous, active-high reset.
- `i_req_valid` in `NUM_REQ`: per-requester word valid.
- `i_req_data` in `NUM_REQ*DATA_WIDTH`: requester k's word is in slice `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `i_req_last` in `NUM_REQ`: marks the final word of a burst.
- `o_req_ready` out `NUM_REQ`: one-hot or zero. A beat transfers on `valid & ready`.
- `o_w_data` out `DATA_WIDTH`: drives the FIFO `i_w_data`.
- `o_w_data_stb` out 1: drives the FIFO `i_w_data_stb`.
- `i_fifo_free_size` in `$clog2(FIFO_DEPTH)`: from the FIFO `o_free_size`.
- `o_grant_idx` out `$clog2(NUM_REQ)`: current or last owner.
- `o_busy` out 1: high while in LOCKED.

## Operation
- **States:** IDLE and LOCKED.
- **Registers:** `rr_ptr`, `owner`, `beat_cnt` (width `$clog2(MAX_BURST+1)`).
- **IDLE:**
  - If any `i_req_valid` is set, `owner` becomes the first set bit searching upward from `rr_ptr`, wrapping modulo `NUM_REQ`.
  - Then: `beat_cnt` ← 0, state → LOCKED, `o_grant_idx` ← `owner`.
  - No `o_req_ready` is asserted in IDLE.
- **Credit rule:** `room` = (`i_fifo_free_size` > `o_w_data_stb`).
  - This accounts for the registered strobe whose effect the FIFO count has not yet shown.
- **Ready:** in LOCKED, `o_req_ready[owner]` = `room`; all other bits are 0.
  - `o_req_ready` is combinational from registered state and `i_fifo_free_size`.
- **Beat accepted:**
  - `o_w_data` ← owner's word and `o_w_data_stb` ← 1 on the next edge. Otherwise `o_w_data_stb` ← 0 and `o_w_data` holds its value.
  - `beat_cnt` increments.
- **Burst end:** an accepted beat with `i_req_last[owner]`, or `beat_cnt == MAX_BURST-1`.
  - State → IDLE and `rr_ptr` ← (`owner`+1) mod `NUM_REQ`.
  - The increment wraps explicitly, so non-power-of-two `NUM_REQ` is supported.
- **Owner stalls** (valid low, or `room` low): the arbiter stays in LOCKED indefinitely. There is no timeout.
- **Valid masking:** `i_req_valid` from non-owners is ignored while LOCKED.
- **FIFO full:** when `i_fifo_free_size` = 0, `room` is low and no strobe is issued.
- **Reset values:** state IDLE, `rr_ptr` 0, `owner` 0, `beat_cnt` 0, `o_w_data` 0, `o_w_data_stb` 0, `o_req_ready` 0, `o_grant_idx` 0, `o_busy` 0.
- **Reset mid-burst:** the burst is abandoned. A word accepted in the same cycle as reset is discarded (`o_w_data_stb` 0 next cycle).

## Timing
- Valid seen in IDLE at cycle t:
  - LOCKED and ready possible at t+1.
  - First `o_w_data_stb` at t+2.
- Sustained rate in LOCKED: 1 word per cycle while `room` holds.
- Re-arbitration costs exactly one IDLE cycle between bursts.
- The in-flight credit covers the FIFO's one-cycle flag/count lag. The arbiter never writes when the FIFO count plus pending writes exceeds `FIFO_DEPTH`-1.

## Configuration
- **`FIFO_ARB_BURST_LOCK_EN` defined:** burst locking as described above.
- **Undefined:**
  - Every grant is exactly one beat; `i_req_last` is ignored and `MAX_BURST` is unused.
  - Requesters strictly alternate round-robin per word; peak throughput is 1 word per 2 cycles.

## Structure
- **Package `fifo_arb_pkg`:**
  - State encoding constants `ST_IDLE` = 0 and `ST_LOCKED` = 1.
  - A `clog2`-based width helper for index and beat counters.
- **Sub-module `rr_priority_picker`:** combinational.
  - Inputs: request vector and `rr_ptr`.
  - Outputs: `found` and `idx`.
  - Reusable by other arbiters.

## Test plan
- **Single requester burst:** req0 sends A,B,C with last on C; free_size 7.
  - Ready high for 3 cycles.
  - Strobes A,B,C on consecutive cycles, starting 2 cycles after valid.
  - Then IDLE; `rr_ptr` = 1.
- **Fairness:** req0 and req2 continuously valid, each sending 1-word bursts.
  - Grant order 0,2,0,2.
  - `o_grant_idx` matches each burst.
- **Credit limit:** free_size = 1 with `o_w_data_stb` = 1 → ready low that cycle.
  - Next cycle free_size = 1 and stb = 0 → ready high, one word written.
- **Burst cap:** `MAX_BURST` = 4; req1 sends 6 words with no last while req3 is also valid.
  - 4 words from req1, then req3 is granted, then req1 resumes.
- **Reset mid-burst:** reset on the 2nd beat.
  - Next cycle: stb 0, state IDLE, `rr_ptr` 0, all ready 0.
- **Macro off:** req0 and req1 continuously valid.
  - Words alternate 0,1,0,1, with a strobe every 2 cycles.
